adder_arbiter: RTL and testbench

//  Shares one signed_adder instance between two requesters (e.g. ALU issue port and

---
 rtl/adder_arbiter.sv | 163 ++++++++++++++++
 tb/tb_adder_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// ----------------------------------------------------------------------------
// adder_arbiter
//   Shares one signed_adder between two requesters with round-robin
//   arbitration and valid/ready handshakes. The granted operands go through
//   the adder and the result/overflow are registered. They are then held on
//   a single response port until the consumer accepts them. A saturating
//   counter tracks accepted responses that carried an overflow.
//
// Ports
//   clk          : single clock, all state updates on the rising edge
//   rst_n        : synchronous reset, active-low
//   req0_valid   : requester 0 has operands
//   req0_ready   : requester 0 operands accepted this cycle (combinational)
//   req0_a/b     : requester 0 operands, SIZE bits
//   req1_valid   : requester 1 has operands
//   req1_ready   : requester 1 operands accepted this cycle (combinational)
//   req1_a/b     : requester 1 operands, SIZE bits
//   rsp_valid    : response held valid
//   rsp_ready    : consumer accepts the response
//   rsp_id       : requester that owns the response
//   rsp_result   : registered adder result, SIZE+1 bits
//   rsp_overflow : registered adder overflow
//   ovf_count    : saturating count of accepted responses with overflow set
//
// signed_adder (same file)
//   Unsigned-extended sum with the carry in bit SIZE. Overflow is the
//   carry-out OR the two's-complement signed overflow.
// ----------------------------------------------------------------------------

module signed_adder #(
    parameter int unsigned SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE:0]   result,
    output logic            overflow
);

    logic [SIZE:0] sum_s;

    // Zero-extended add; carry lands in bit SIZE.
    always_comb begin
        sum_s    = {1'b0, a} + {1'b0, b};
        result   = sum_s;
        overflow = sum_s[SIZE]
                 | ((a[SIZE-1] == b[SIZE-1]) & (sum_s[SIZE-1] != a[SIZE-1]));
    end

endmodule

module adder_arbiter #(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned OVF_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [SIZE-1:0]   req0_a,
    input  logic [SIZE-1:0]   req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [SIZE-1:0]   req1_a,
    input  logic [SIZE-1:0]   req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [SIZE:0]     rsp_result,
    output logic              rsp_overflow,
    output logic [OVF_W-1:0]  ovf_count
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam logic [OVF_W-1:0] OVF_MAX = {OVF_W{1'b1}};

    state_t            state_r;
    logic              last_grant_r;
    logic              can_issue_s;
    logic              grant_s;
    logic              issue_s;
    logic              rsp_done_s;
    logic [SIZE-1:0]   op_a_s;
    logic [SIZE-1:0]   op_b_s;
    logic [SIZE:0]     sum_s;
    logic              sum_ovf_s;

    // Arbitration, handshake readies and operand mux into the shared adder.
    always_comb begin
        can_issue_s = (state_r == IDLE) | ((state_r == RESP) & rsp_ready);
        rsp_done_s  = (state_r == RESP) & rsp_ready;

        if (req0_valid & req1_valid) begin
            // Tie goes to whoever was not granted last.
            grant_s = ~last_grant_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end

        // Gated by rst_n so no handshake can complete while reset is held.
        req0_ready = rst_n & can_issue_s & ~grant_s & req0_valid;
        req1_ready = rst_n & can_issue_s &  grant_s & req1_valid;
        issue_s    = req0_ready | req1_ready;

        if (grant_s) begin
            op_a_s = req1_a;
            op_b_s = req1_b;
        end else begin
            op_a_s = req0_a;
            op_b_s = req0_b;
        end
    end

    signed_adder #(
        .SIZE (SIZE)
    ) u_adder (
        .a        (op_a_s),
        .b        (op_b_s),
        .result   (sum_s),
        .overflow (sum_ovf_s)
    );

    // Response FSM, registered response fields and overflow counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            ovf_count    <= '0;
        end else begin
            if (issue_s) begin
                // New grant: capture, even if the previous response is leaving this cycle.
                state_r      <= RESP;
                rsp_valid    <= 1'b1;
                rsp_id       <= grant_s;
                last_grant_r <= grant_s;
                rsp_result   <= sum_s;
                rsp_overflow <= sum_ovf_s;
            end else if (rsp_done_s) begin
                state_r   <= IDLE;
                rsp_valid <= 1'b0;
            end else begin
                state_r   <= state_r;
                rsp_valid <= rsp_valid;
            end

            if (rsp_done_s && rsp_overflow && (ovf_count != OVF_MAX)) begin
                ovf_count <= ovf_count + OVF_W'(1);
            end else begin
                ovf_count <= ovf_count;
            end
        end
    end

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_a, req0_b, req1_a, req1_b;
    logic        rsp_ready;

    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_overflow;
    logic [8:0]  rsp_result;
    logic [7:0]  ovf_count;

    logic        s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_rsp_overflow;
    logic [8:0]  s_rsp_result;
    logic [1:0]  s_ovf_count;

    int checks   = 0;
    int failures = 0;

    adder_arbiter #(.SIZE(8), .OVF_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .ovf_count(ovf_count)
    );

    // Narrow-counter copy sharing the same stimulus, used for saturation.
    adder_arbiter #(.SIZE(8), .OVF_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id),
        .rsp_result(s_rsp_result), .rsp_overflow(s_rsp_overflow), .ovf_count(s_ovf_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       v0;
        logic [7:0] a0, b0;
        logic       v1;
        logic [7:0] a1, b1;
        logic       rr;
        logic       e_r0, e_r1;
        logic       e_v;
        logic       e_id;
        logic [8:0] e_res;
        logic       e_ov;
        logic [7:0] e_ovf;
        logic [1:0] e_ovf2;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [7:0] a0, input logic [7:0] b0,
                         input logic v1, input logic [7:0] a1, input logic [7:0] b1,
                         input logic rr);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        rsp_ready  = rr;
    endtask

    logic [8:0] held_res;

    initial begin
        //                v0    a0     b0     v1    a1     b1     rr    r0    r1    v     id    res     ov    ovf    ovf2
        vecs[0] = '{1'b1, 8'h03, 8'h04, 1'b1, 8'h10, 8'h20, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9'h007, 1'b0, 8'd0, 2'd0};
        vecs[1] = '{1'b1, 8'h05, 8'h06, 1'b1, 8'h10, 8'h20, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'h030, 1'b0, 8'd0, 2'd0};
        vecs[2] = '{1'b1, 8'h05, 8'h06, 1'b1, 8'hFF, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9'h00B, 1'b0, 8'd0, 2'd0};
        vecs[3] = '{1'b1, 8'h7F, 8'h01, 1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 9'h100, 1'b1, 8'd0, 2'd0};
        vecs[4] = '{1'b1, 8'h7F, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 9'h080, 1'b1, 8'd1, 2'd1};
        vecs[5] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 8'd2, 2'd2};
        vecs[6] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 8'd2, 2'd2};

        // Reset held with both requesters valid.
        rst_n = 1'b0;
        drive(1'b1, 8'h03, 8'h04, 1'b1, 8'h10, 8'h20, 1'b1);
        tick();
        tick();
        chk("reset_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("reset_req1_ready", {31'd0, req1_ready}, 32'd0);
        chk("reset_rsp_valid",  {31'd0, rsp_valid},  32'd0);
        chk("reset_ovf_count",  {24'd0, ovf_count},  32'd0);
        chk("reset_rsp_result", {23'd0, rsp_result}, 32'd0);
        rst_n = 1'b1;

        // Table: single, round-robin, overflow, drain.
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].rr);
            #1;
            chk($sformatf("v%0d_req0_ready", i), {31'd0, req0_ready}, {31'd0, vecs[i].e_r0});
            chk($sformatf("v%0d_req1_ready", i), {31'd0, req1_ready}, {31'd0, vecs[i].e_r1});
            tick();
            chk($sformatf("v%0d_rsp_valid", i), {31'd0, rsp_valid}, {31'd0, vecs[i].e_v});
            if (vecs[i].e_v) begin
                chk($sformatf("v%0d_rsp_id", i),       {31'd0, rsp_id},       {31'd0, vecs[i].e_id});
                chk($sformatf("v%0d_rsp_result", i),   {23'd0, rsp_result},   {23'd0, vecs[i].e_res});
                chk($sformatf("v%0d_rsp_overflow", i), {31'd0, rsp_overflow}, {31'd0, vecs[i].e_ov});
            end
            chk($sformatf("v%0d_ovf_count", i),     {24'd0, ovf_count},   {24'd0, vecs[i].e_ovf});
            chk($sformatf("v%0d_sat_ovf_count", i), {30'd0, s_ovf_count}, {30'd0, vecs[i].e_ovf2});
        end

        // Backpressure: response held for 3 cycles, both requesters waiting.
        drive(1'b1, 8'h01, 8'h02, 1'b0, 8'h00, 8'h00, 1'b0);
        #1;
        chk("bp_accept_req0", {31'd0, req0_ready}, 32'd1);
        tick();
        chk("bp_rsp_result", {23'd0, rsp_result}, 32'h003);
        held_res = rsp_result;
        drive(1'b1, 8'h09, 8'h01, 1'b1, 8'h02, 8'h02, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d_req0_ready", i), {31'd0, req0_ready}, 32'd0);
            chk($sformatf("bp%0d_req1_ready", i), {31'd0, req1_ready}, 32'd0);
            tick();
            chk($sformatf("bp%0d_rsp_valid", i),  {31'd0, rsp_valid},  32'd1);
            chk($sformatf("bp%0d_rsp_id", i),     {31'd0, rsp_id},     32'd0);
            chk($sformatf("bp%0d_rsp_result", i), {23'd0, rsp_result}, {23'd0, held_res});
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_req1_ready", {31'd0, req1_ready}, 32'd1);
        chk("bp_release_req0_ready", {31'd0, req0_ready}, 32'd0);
        tick();
        chk("bp_release_rsp_id",     {31'd0, rsp_id},     32'd1);
        chk("bp_release_rsp_result", {23'd0, rsp_result}, 32'h004);

        // Five back-to-back overflow transactions from requester 0.
        drive(1'b1, 8'h80, 8'h80, 1'b0, 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("sat%0d_rsp_result", i),   {23'd0, rsp_result},   32'h100);
            chk($sformatf("sat%0d_rsp_overflow", i), {31'd0, rsp_overflow}, 32'd1);
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
        tick();
        chk("sat_rsp_valid_drained", {31'd0, rsp_valid},   32'd0);
        chk("sat_ovf_count_wide",    {24'd0, ovf_count},   32'd7);
        chk("sat_ovf_count_narrow",  {30'd0, s_ovf_count}, 32'd3);

        // Reset while a response is held under backpressure.
        drive(1'b1, 8'h03, 8'h04, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        chk("midrst_rsp_valid_before", {31'd0, rsp_valid}, 32'd1);
        rst_n = 1'b0;
        drive(1'b1, 8'h03, 8'h04, 1'b1, 8'h05, 8'h05, 1'b0);
        #1;
        chk("midrst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("midrst_req1_ready", {31'd0, req1_ready}, 32'd0);
        tick();
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_ovf_count", {24'd0, ovf_count}, 32'd0);
        chk("midrst_sat_ovf",   {30'd0, s_ovf_count}, 32'd0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("midrst_first_grant_req0", {31'd0, req0_ready}, 32'd1);
        chk("midrst_first_grant_req1", {31'd0, req1_ready}, 32'd0);
        tick();
        chk("midrst_rsp_id",     {31'd0, rsp_id},     32'd0);
        chk("midrst_rsp_result", {23'd0, rsp_result}, 32'h007);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
